// File: rtl/fp_align_pkg.sv
// Shared types and constants for the parametrised mantissa align/add stage.
package fp_align_pkg;

   // Number of guard/round/sticky bits carried below the mantissa LSB
   localparam int GRS_W = 3;

   // Control states of the align/add sequencer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      ADD   = 2'd2,
      DONE  = 2'd3
   } fpStateT;

   // Exponent difference at or beyond which every bit of the small operand,
   // including its GRS extension, would be shifted out
   function automatic int farThreshold(input int manW);
      return manW + GRS_W;
   endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// Combinational right shift by 0..SHIFT_STEP that folds every bit shifted out
// into the result LSB, so repeated shifts keep an exact sticky bit.
module fp_sticky_shift #(
   parameter int W          = 27,
   parameter int SHIFT_STEP = 4,
   parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
   input  logic [W-1:0]     dataIn,
   input  logic [AMT_W-1:0] amount,
   output logic [W-1:0]     dataOut
);

   logic [W-1:0] lostMask;
   logic         lostAny;

   // Shift right, then OR any discarded bit into the surviving LSB so the
   // sticky information is never lost across several partial shifts
   always_comb begin
      lostMask   = (W'(1) << amount) - W'(1);
      lostAny    = |(dataIn & lostMask);
      dataOut    = dataIn >> amount;
      dataOut[0] = dataOut[0] | lostAny;
   end

endmodule

// File: rtl/fp_align_add_param.sv
// Mantissa alignment and magnitude add/subtract stage. A captured request is
// ordered (big/small), the small operand is aligned a few bits per cycle with
// sticky preservation, and the un-normalised result is registered for the
// downstream normaliser/rounder.
module fp_align_add_param
   import fp_align_pkg::*;
#(
   parameter int EXP_W      = 8,
   parameter int MAN_W      = 24,
   parameter int SHIFT_STEP = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Load,
   input  logic             Op,
   input  logic             S_A,
   input  logic             S_B,
   input  logic [EXP_W-1:0] E_A,
   input  logic [EXP_W-1:0] E_B,
   input  logic [MAN_W-1:0] M_A,
   input  logic [MAN_W-1:0] M_B,
   output logic             Busy,
   output logic             Result_stable,
   output logic             S_Result,
   output logic [EXP_W-1:0] E_Result,
   output logic [MAN_W-1:0] M_Result,
   output logic             Carry,
   output logic [GRS_W-1:0] GRS
);

   localparam int               EXT_W  = MAN_W + GRS_W;
   localparam int               AMT_W  = $clog2(SHIFT_STEP + 1);
   localparam logic [EXP_W-1:0] STEP_E = EXP_W'(SHIFT_STEP);
   localparam logic [EXP_W-1:0] FAR_E  = EXP_W'(farThreshold(MAN_W));

   fpStateT          state, nextState;
   logic             pending, idleLike, acceptLoad, startOp;
   logic             rawSA, rawSB;
   logic [EXP_W-1:0] rawEA, rawEB;
   logic [MAN_W-1:0] rawMA, rawMB;

   logic             aIsBig, ordBigS, ordSmallS;
   logic [EXP_W-1:0] ordBigE, ordDiff;
   logic [MAN_W-1:0] ordBigM, ordSmallM;

   logic             bigS, smallS;
   logic [EXP_W-1:0] bigE, remaining, stepAmt;
   logic [EXT_W-1:0] bigExt, smallExt, shiftedExt, subRes;
   logic [EXT_W:0]   addRes;
   logic [AMT_W-1:0] shiftAmt;
   logic             isFar, effSub;

   fp_sticky_shift #(
      .W          (EXT_W),
      .SHIFT_STEP (SHIFT_STEP),
      .AMT_W      (AMT_W)
   ) u_shift (
      .dataIn  (smallExt),
      .amount  (shiftAmt),
      .dataOut (shiftedExt)
   );

   assign idleLike      = (state == IDLE) || (state == DONE);
   assign acceptLoad    = idleLike && Load && !pending;
   assign startOp       = idleLike && pending;
   assign Busy          = (state == ALIGN) || (state == ADD);
   assign Result_stable = (state == DONE);

   // Order the captured operands so the larger {E, M} is "big"; a full tie
   // keeps A as big, which makes an equal-magnitude subtract come out as zero
   always_comb begin
      aIsBig = {rawEA, rawMA} >= {rawEB, rawMB};
      if (aIsBig) begin
         ordBigS   = rawSA;
         ordSmallS = rawSB;
         ordBigE   = rawEA;
         ordDiff   = rawEA - rawEB;
         ordBigM   = rawMA;
         ordSmallM = rawMB;
      end else begin
         ordBigS   = rawSB;
         ordSmallS = rawSA;
         ordBigE   = rawEB;
         ordDiff   = rawEB - rawEA;
         ordBigM   = rawMB;
         ordSmallM = rawMA;
      end
   end

   // Per-cycle alignment step: at most SHIFT_STEP, never past the remaining
   // distance; a far difference is collapsed to a single sticky-only cycle
   always_comb begin
      isFar    = remaining >= FAR_E;
      stepAmt  = (remaining >= STEP_E) ? STEP_E : remaining;
      shiftAmt = AMT_W'(stepAmt);
   end

   // Magnitude add or subtract on the GRS-extended mantissas
   always_comb begin
      effSub = bigS ^ smallS;
      addRes = {1'b0, bigExt} + {1'b0, smallExt};
      subRes = bigExt - smallExt;
   end

   // Sequencer: a captured request starts on the following cycle, going
   // straight to ADD when exponents already match
   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: if (startOp) nextState = (ordDiff == '0) ? ADD : ALIGN;
         ALIGN:      if (isFar || (remaining == stepAmt)) nextState = ADD;
         ADD:        nextState = DONE;
         default:    nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= nextState;
   end

   // Request capture; B's sign is stored already flipped for a subtract
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pending <= 1'b0;
         rawSA   <= 1'b0;
         rawSB   <= 1'b0;
         rawEA   <= '0;
         rawEB   <= '0;
         rawMA   <= '0;
         rawMB   <= '0;
      end else begin
         pending <= acceptLoad;
         if (acceptLoad) begin
            rawSA <= S_A;
            rawSB <= S_B ^ Op;
            rawEA <= E_A;
            rawEB <= E_B;
            rawMA <= M_A;
            rawMB <= M_B;
         end
      end
   end

   // Working operands: load the ordered pair, then walk the small mantissa
   // right until the remaining distance is used up
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bigS      <= 1'b0;
         smallS    <= 1'b0;
         bigE      <= '0;
         bigExt    <= '0;
         smallExt  <= '0;
         remaining <= '0;
      end else if (startOp) begin
         bigS      <= ordBigS;
         smallS    <= ordSmallS;
         bigE      <= ordBigE;
         bigExt    <= {ordBigM, {GRS_W{1'b0}}};
         smallExt  <= {ordSmallM, {GRS_W{1'b0}}};
         remaining <= ordDiff;
      end else if (state == ALIGN) begin
         if (isFar) begin
            smallExt  <= EXT_W'(|smallExt);
            remaining <= '0;
         end else begin
            smallExt  <= shiftedExt;
            remaining <= remaining - stepAmt;
         end
      end
   end

   // Result registers load only when leaving ADD and hold until the next one
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         S_Result <= 1'b0;
         E_Result <= '0;
         M_Result <= '0;
         Carry    <= 1'b0;
         GRS      <= '0;
      end else if (state == ADD) begin
         E_Result <= bigE;
         if (effSub) begin
            S_Result <= (subRes == '0) ? 1'b0 : bigS;
            M_Result <= subRes[EXT_W-1:GRS_W];
            GRS      <= subRes[GRS_W-1:0];
            Carry    <= 1'b0;
         end else begin
            S_Result <= bigS;
            M_Result <= addRes[EXT_W-1:GRS_W];
            GRS      <= addRes[GRS_W-1:0];
            Carry    <= addRes[EXT_W];
         end
      end
   end

endmodule

// File: tb/tb_fp_align_add_param.sv
// Self-checking bench for fp_align_add_param: directed cases plus randomized
// operands compared against a one-shot arithmetic reference model.
module tb_fp_align_add_param;

   localparam int EXP_W      = 8;
   localparam int MAN_W      = 24;
   localparam int SHIFT_STEP = 4;
   localparam int FAR        = MAN_W + 3;

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
      logic        carry;
      logic [2:0]  grs;
      int          lat;
   } expT;

   logic        Clk, Reset_n, Load, Op, S_A, S_B;
   logic [7:0]  E_A, E_B;
   logic [23:0] M_A, M_B;
   logic        Busy, Result_stable, S_Result, Carry;
   logic [7:0]  E_Result;
   logic [23:0] M_Result;
   logic [2:0]  GRS;

   int          checks, errors;
   logic [23:0] lastM;
   int          rEA, rEB, mode, tmp;
   logic        rsA, rsB, rOp;
   logic [23:0] rMA, rMB;

   fp_align_add_param #(
      .EXP_W      (EXP_W),
      .MAN_W      (MAN_W),
      .SHIFT_STEP (SHIFT_STEP)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .Load          (Load),
      .Op            (Op),
      .S_A           (S_A),
      .S_B           (S_B),
      .E_A           (E_A),
      .E_B           (E_B),
      .M_A           (M_A),
      .M_B           (M_B),
      .Busy          (Busy),
      .Result_stable (Result_stable),
      .S_Result      (S_Result),
      .E_Result      (E_Result),
      .M_Result      (M_Result),
      .Carry         (Carry),
      .GRS           (GRS)
   );

   // Free-running clock, 10 time units per period
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference result computed in one step with plain integer arithmetic:
   // exact right shift with sticky, then signed-magnitude add or subtract
   function automatic expT refModel(input logic sa, input logic sb, input int ea, input int eb,
                                    input logic [23:0] ma, input logic [23:0] mb, input logic op);
      expT    r;
      longint bigMag, smallMag, res, lost;
      int     d;
      logic   sbEff, aBig, sBig, sSmall;
      sbEff    = sb ^ op;
      aBig     = (ea > eb) || ((ea == eb) && (ma >= mb));
      bigMag   = longint'(aBig ? ma : mb) * 8;
      smallMag = longint'(aBig ? mb : ma) * 8;
      d        = aBig ? (ea - eb) : (eb - ea);
      sBig     = aBig ? sa : sbEff;
      sSmall   = aBig ? sbEff : sa;
      if (d >= FAR) smallMag = (smallMag != 0) ? 1 : 0;
      else if (d > 0) begin
         lost     = smallMag % (longint'(1) << d);
         smallMag = (smallMag >> d) | ((lost != 0) ? 1 : 0);
      end
      if (sBig == sSmall) begin
         res     = bigMag + smallMag;
         r.carry = ((res >> 27) & 1) != 0;
         r.s     = sBig;
      end else begin
         res     = bigMag - smallMag;
         r.carry = 1'b0;
         r.s     = (res == 0) ? 1'b0 : sBig;
      end
      r.m   = 24'((res >> 3) & 64'hFFFFFF);
      r.grs = 3'(res & 7);
      r.e   = 8'(aBig ? ea : eb);
      if (d == 0)        r.lat = 2;
      else if (d >= FAR) r.lat = 3;
      else               r.lat = 2 + (d + SHIFT_STEP - 1) / SHIFT_STEP;
      return r;
   endfunction

   // One comparison: count it, and report tag/observed/expected on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue one operation, measure its latency and compare every result field;
   // optionally pulse Load again while the operation is in flight
   task automatic applyStimulus(input logic sa, input logic sb, input int ea, input int eb,
                                input logic [23:0] ma, input logic [23:0] mb, input logic op,
                                input bit glitch, input string tag);
      expT exp;
      int  lat;
      bit  wasDone;
      exp = refModel(sa, sb, ea, eb, ma, mb, op);
      @(negedge Clk);
      wasDone = Result_stable;
      S_A = sa; S_B = sb; E_A = 8'(ea); E_B = 8'(eb);
      M_A = ma; M_B = mb; Op = op; Load = 1'b1;
      @(posedge Clk); #1;
      Load = 1'b0;
      if (wasDone) begin
         checkOutput({tag, "_hold_stable"}, 32'(Result_stable), 32'd1);
         checkOutput({tag, "_hold_m"}, 32'(M_Result), 32'(lastM));
      end
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge Clk); #1;
         if (k == 2) Load = 1'b0;
         checkOutput({tag, "_excl"}, 32'(Busy & Result_stable), 32'd0);
         if (Result_stable) begin
            lat = k;
            break;
         end
         if (k == 1) begin
            checkOutput({tag, "_busy"}, 32'(Busy), 32'd1);
            if (glitch) begin
               Load = 1'b1; E_A = 8'd5; E_B = 8'd5; M_A = 24'hFFFFFF; S_A = 1'b1;
            end
         end
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp.lat));
      checkOutput({tag, "_s"}, 32'(S_Result), 32'(exp.s));
      checkOutput({tag, "_e"}, 32'(E_Result), 32'(exp.e));
      checkOutput({tag, "_m"}, 32'(M_Result), 32'(exp.m));
      checkOutput({tag, "_carry"}, 32'(Carry), 32'(exp.carry));
      checkOutput({tag, "_grs"}, 32'(GRS), 32'(exp.grs));
      lastM = exp.m;
   endtask

   // Directed sequence, reset-in-flight scenario, then randomized operations
   initial begin
      checks = 0; errors = 0; lastM = '0;
      Reset_n = 1'b0; Load = 1'b0; Op = 1'b0; S_A = 1'b0; S_B = 1'b0;
      E_A = '0; E_B = '0; M_A = '0; M_B = '0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("reset_busy",   32'(Busy), 32'd0);
      checkOutput("reset_stable", 32'(Result_stable), 32'd0);
      checkOutput("reset_m",      32'(M_Result), 32'd0);
      checkOutput("reset_e",      32'(E_Result), 32'd0);
      checkOutput("reset_misc",   32'({S_Result, Carry, GRS}), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      applyStimulus(0, 0, 130, 120, 24'h800000, 24'h800000, 0, 0, "add_d10");
      applyStimulus(1, 0, 130, 120, 24'h800000, 24'h800000, 0, 0, "mixed_d10");
      applyStimulus(0, 0, 130, 120, 24'h800000, 24'h800000, 1, 0, "opsub_d10");
      applyStimulus(1, 0, 120, 120, 24'h800000, 24'h800000, 0, 0, "zero");
      applyStimulus(1, 1, 120, 120, 24'h800000, 24'h800000, 0, 0, "carry");
      applyStimulus(0, 0, 120, 130, 24'hC00001, 24'h800000, 0, 0, "swap");
      applyStimulus(0, 0, 200, 100, 24'h800000, 24'h800001, 0, 0, "far");
      applyStimulus(0, 0, 200, 100, 24'h800000, 24'h800001, 0, 1, "far_glitch");
      applyStimulus(0, 1, 150, 150 - FAR + 1, 24'hABCDEF, 24'hFFFFFF, 0, 0, "near_far");

      // Reset asserted while the far-case operation is aligning
      @(negedge Clk);
      S_A = 0; S_B = 0; E_A = 8'd200; E_B = 8'd100;
      M_A = 24'h800000; M_B = 24'h800001; Op = 0; Load = 1'b1;
      @(posedge Clk); #1;
      Load = 1'b0;
      @(posedge Clk); #1;
      checkOutput("rst_pre_busy", 32'(Busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      checkOutput("rst_busy",   32'(Busy), 32'd0);
      checkOutput("rst_stable", 32'(Result_stable), 32'd0);
      checkOutput("rst_m",      32'(M_Result), 32'd0);
      checkOutput("rst_e",      32'(E_Result), 32'd0);
      checkOutput("rst_misc",   32'({S_Result, Carry, GRS}), 32'd0);
      @(posedge Clk); #1;
      checkOutput("rst_idle_busy", 32'(Busy | Result_stable), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      lastM = '0;
      applyStimulus(0, 0, 130, 120, 24'h800000, 24'h800000, 0, 0, "post_reset");

      for (int i = 0; i < 40; i++) begin
         rEA  = int'($urandom_range(30, 220));
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       rEB = rEA;
            1:       rEB = rEA - int'($urandom_range(1, FAR - 1));
            2:       rEB = rEA - int'($urandom_range(FAR, 30));
            default: rEB = int'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            tmp = rEA; rEA = rEB; rEB = tmp;
         end
         rMA = 24'h800000 | 24'($urandom);
         rMB = 24'h800000 | 24'($urandom);
         if ($urandom_range(0, 3) == 0) rMB = rMA;
         rsA = 1'($urandom);
         rsB = 1'($urandom);
         rOp = 1'($urandom);
         applyStimulus(rsA, rsB, rEA, rEB, rMA, rMB, rOp, 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
